// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the time-shared
// single-precision multiplier and its scheduler.
package fp_mul_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MAX = 10'sd255;
  localparam logic [31:0]       QNAN    = 32'h7FC00000;
  localparam logic [31:0]       POS_INF = 32'h7F800000;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NAN  = 3;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } sched_state_t;

endpackage

// File: rtl/fp_mul_core.sv
// Combinational fp32 multiply: truncating, denormals
// flushed to zero, one-hot exception flags.
module fp_mul_core
  import fp_mul_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);

  fp32_t a;
  fp32_t b;
  logic  a_zero, b_zero;
  logic  a_inf, b_inf;
  logic  a_nan, b_nan;
  logic  sign;
  logic  [47:0] prod;
  logic  signed [9:0] exp9;
  logic  [22:0] man;
  logic  unused_lsbs;

  assign a = fp32_t'(x_i);
  assign b = fp32_t'(y_i);
  assign unused_lsbs = ^prod[22:0];

  always_comb begin
    a_zero = (a.exp == 8'h00);
    b_zero = (b.exp == 8'h00);
    a_inf  = (a.exp == 8'hFF) && (a.man == '0);
    b_inf  = (b.exp == 8'hFF) && (b.man == '0);
    a_nan  = (a.exp == 8'hFF) && (a.man != '0);
    b_nan  = (b.exp == 8'hFF) && (b.man != '0);
    sign   = a.sign ^ b.sign;
    prod   = {24'd0, 1'b1, a.man} * {24'd0, 1'b1, b.man};
    exp9   = $signed({2'b00, a.exp})
           + $signed({2'b00, b.exp}) - BIAS;
    man    = prod[45:23];
    if (prod[47]) begin
      exp9 = exp9 + 10'sd1;
      man  = prod[46:24];
    end
    result_o = {sign, exp9[7:0], man};
    flags_o  = '0;
    // Ordered by exception priority
    if (a_nan || b_nan || (a_zero && b_inf)
        || (a_inf && b_zero)) begin
      result_o = QNAN;
      flags_o[FLAG_NAN] = 1'b1;
    end else if (a_inf || b_inf) begin
      result_o = {sign, POS_INF[30:0]};
    end else if (a_zero || b_zero) begin
      result_o = {sign, 31'd0};
      flags_o[FLAG_ZERO] = 1'b1;
    end else if (exp9 >= EXP_MAX) begin
      result_o = {sign, 8'hFF, 23'd0};
      flags_o[FLAG_OVF] = 1'b1;
    end else if (exp9 <= 10'sd0) begin
      result_o = {sign, 31'd0};
      flags_o[FLAG_UNF] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one fp32 multiplier
// core between two valid/ready requesters.
module fp_mul_sched
  import fp_mul_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][W-1:0]   req_x,
  input  logic [NREQ-1:0][W-1:0]   req_y,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [W-1:0]             rsp_result,
  output logic [3:0]               rsp_flags,
  output logic                     busy
);

  sched_state_t state_q, state_d;
  logic         last_q, last_d;
  logic         owner_q, owner_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] res_q, res_d;
  logic [3:0]   flags_q, flags_d;
  logic         grant;
  logic [W-1:0] core_res;
  logic [3:0]   core_flags;

  fp_mul_core u_core (
    .x_i      (x_q),
    .y_i      (y_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  // Contention goes to whoever was not served last
  assign grant = req_valid[1]
               & (~req_valid[0] | ~last_q);

  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    x_d       = x_q;
    y_d       = y_q;
    res_d     = res_q;
    flags_d   = flags_q;
    req_ready = '0;
    rsp_valid = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          x_d     = req_x[grant];
          y_d     = req_y[grant];
          owner_d = grant;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        res_d   = core_res;
        flags_d = core_flags;
        last_d  = owner_q;
        state_d = RESPOND;
      end
      RESPOND: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched: vector table plus
// arbitration, stall and async-reset sequences.
module tb_fp_mul_sched;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_x;
  logic [1:0][31:0] req_y;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic             busy;

  int tests;
  int fails;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vt[16];

  fp_mul_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic do_op(input int r,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] er,
                       input logic [3:0] ef,
                       input string nm);
    logic [1:0] oh;
    oh = 2'b01 << r;
    @(negedge clk);
    req_valid = oh;
    req_x[r] = x;
    req_y[r] = y;
    #1;
    chk({nm, " req_ready"}, {30'd0, req_ready}, {30'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
    chk({nm, " busy_c"}, {31'd0, busy}, 32'd1);
    chk({nm, " rsp_v_c"}, {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({nm, " rsp_valid"}, {30'd0, rsp_valid}, {30'd0, oh});
    chk({nm, " result"}, rsp_result, er);
    chk({nm, " flags"}, {28'd0, rsp_flags}, {28'd0, ef});
    rsp_ready = oh;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk({nm, " busy_end"}, {31'd0, busy}, 32'd0);
    chk({nm, " rsp_v_end"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vt[0]  = '{32'hC1900000, 32'h41180000, 32'hC32B0000, 4'b0000};
    vt[1]  = '{32'h80000000, 32'h419F6000, 32'h80000000, 4'b0001};
    vt[2]  = '{32'h80000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
    vt[3]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100};
    vt[4]  = '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0010};
    vt[5]  = '{32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000};
    vt[6]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000};
    vt[7]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vt[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000};
    vt[9]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0000};
    vt[10] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0001};
    vt[11] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0100};
    vt[12] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000};
    vt[13] = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0010};
    vt[14] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vt[15] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};

    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_x = '0;
    req_y = '0;
    reset = 1'b1;
    #2;
    chk("rst req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst result", rsp_result, 32'd0);
    chk("rst flags", {28'd0, rsp_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(i % 2, vt[i].x, vt[i].y, vt[i].res, vt[i].fl,
            $sformatf("v%0d", i));

    // Arbitration after reset
    do_reset();
    @(negedge clk);
    req_valid = 2'b11;
    req_x[0] = 32'h3F800000; req_y[0] = 32'h40000000;
    req_x[1] = 32'h3FC00000; req_y[1] = 32'h3FC00000;
    #1;
    chk("rr first grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rr compute ready", {30'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rr rsp0 valid", {30'd0, rsp_valid}, 32'd1);
    chk("rr rsp0 result", rsp_result, 32'h40000000);
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("rr nonowner ignored", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("rr second grant", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    @(negedge clk);
    chk("rr rsp1 valid", {30'd0, rsp_valid}, 32'd2);
    chk("rr rsp1 result", rsp_result, 32'h40100000);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("rr third grant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rr no accept", {31'd0, busy}, 32'd0);

    // Stalled response with competing requester
    @(negedge clk);
    req_valid = 2'b01;
    req_x[0] = 32'hC1900000; req_y[0] = 32'h41180000;
    req_x[1] = 32'h40000000; req_y[1] = 32'h40000000;
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d result", i), rsp_result, 32'hC32B0000);
      chk($sformatf("stall%0d rsp_v", i), {30'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d ready", i), {30'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d busy", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("stall other grant", {30'd0, req_ready}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("stall rsp1 valid", {30'd0, rsp_valid}, 32'd2);
    chk("stall rsp1 result", rsp_result, 32'h40800000);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("stall done busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset while computing
    @(negedge clk);
    req_valid = 2'b10;
    req_x[1] = 32'h3FC00000; req_y[1] = 32'h3FC00000;
    @(negedge clk);
    req_valid = 2'b00;
    chk("arst pre busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("arst result", rsp_result, 32'd0);
    chk("arst flags", {28'd0, rsp_flags}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("arst idle", {31'd0, busy}, 32'd0);
    req_valid = 2'b11;
    req_x[0] = 32'h7F000000; req_y[0] = 32'h7F000000;
    #1;
    chk("arst prio0", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("arst rsp valid", {30'd0, rsp_valid}, 32'd1);
    chk("arst rsp result", rsp_result, 32'h7F800000);
    chk("arst rsp flags", {28'd0, rsp_flags}, 32'd4);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    chk("arst end busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
